// File: rtl/bsg_counter_up_down_variable_multi_sat.sv
// bsg_counter_up_down_variable_multi_sat: bank of independent saturating up/down counters with variable step
//
// Each channel adds up_i and subtracts down_i every cycle. The result clamps at
// 0 and max_val_p instead of wrapping. A single write port can load one channel
// per cycle. Loaded values above the ceiling are clamped.
//
// Optional feature macro: BSG_COUNTER_UP_DOWN_VARIABLE_MULTI_SAT_STICKY_ERR_EN
//   defined   : overflow_o/underflow_o stay set until clear_err_i or reset_i.
//               An event in the same cycle as clear_err_i wins.
//   undefined : the flags pulse high for the one cycle after an event, and
//               clear_err_i is ignored.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset; has priority over load and steps
//   up_i         per-channel increment; channel i is at [i*step_w_lp +: step_w_lp]
//   down_i       per-channel decrement; packed the same way as up_i
//   load_v_i     load strobe; always accepted
//   load_id_i    channel to load; an id >= els_p does nothing
//   load_val_i   value to load; clamped to max_val_p
//   clear_err_i  clears the sticky flags (sticky build only)
//   count_o      registered counts; channel i is at [i*cnt_w_lp +: cnt_w_lp]
//   zero_o       high when the registered count of that channel is 0
//   overflow_o   ceiling-clamp flag per channel
//   underflow_o  floor-clamp flag per channel
module bsg_counter_up_down_variable_multi_sat #(
    parameter int els_p      = 4,
    parameter int max_val_p  = 10000000,
    parameter int init_val_p = 100,
    parameter int max_step_p = 4,
    localparam int cnt_w_lp  = $clog2(max_val_p + 1),
    localparam int step_w_lp = $clog2(max_step_p + 1),
    localparam int id_w_lp   = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [els_p*step_w_lp-1:0]    up_i,
    input  logic [els_p*step_w_lp-1:0]    down_i,
    input  logic                          load_v_i,
    input  logic [id_w_lp-1:0]            load_id_i,
    input  logic [cnt_w_lp-1:0]           load_val_i,
    input  logic                          clear_err_i,
    output logic [els_p*cnt_w_lp-1:0]     count_o,
    output logic [els_p-1:0]              zero_o,
    output logic [els_p-1:0]              overflow_o,
    output logic [els_p-1:0]              underflow_o
);
    // Two extra bits: one for the sign, one so that max + step cannot wrap.
    localparam int sum_w_lp = cnt_w_lp + 2;
    localparam logic [cnt_w_lp-1:0]  max_lp  = cnt_w_lp'(max_val_p);
    localparam logic [cnt_w_lp-1:0]  init_lp = cnt_w_lp'(init_val_p);
    localparam logic [step_w_lp-1:0] step_lp = step_w_lp'(max_step_p);

`ifndef BSG_COUNTER_UP_DOWN_VARIABLE_MULTI_SAT_STICKY_ERR_EN
    logic unused_clear_err;
    assign unused_clear_err = clear_err_i;
`endif

    for (genvar i = 0; i < els_p; i++) begin : ch
        logic [step_w_lp-1:0]       up, dn;
        logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
        logic signed [sum_w_lp-1:0] sum;
        logic                       load_hit, ovf_ev, unf_ev;
        logic                       ovf_q, ovf_d, unf_q, unf_d;

        assign up = up_i[i*step_w_lp +: step_w_lp];
        assign dn = down_i[i*step_w_lp +: step_w_lp];

        always_comb begin
            load_hit = load_v_i && (load_id_i == id_w_lp'(i));
            sum      = $signed({2'b00, cnt_q}) - $signed(sum_w_lp'(dn)) + $signed(sum_w_lp'(up));
            // A load replaces this channel's steps; only the ceiling clamp can happen.
            unf_ev   = !load_hit && (sum < 0);
            ovf_ev   = load_hit ? (load_val_i > max_lp) : (sum > $signed({2'b00, max_lp}));
            cnt_d    = load_hit ? (ovf_ev ? max_lp : load_val_i)
                     : unf_ev   ? '0
                     : ovf_ev   ? max_lp
                     : sum[cnt_w_lp-1:0];
`ifdef BSG_COUNTER_UP_DOWN_VARIABLE_MULTI_SAT_STICKY_ERR_EN
            ovf_d    = ovf_ev | (ovf_q & ~clear_err_i);
            unf_d    = unf_ev | (unf_q & ~clear_err_i);
`else
            ovf_d    = ovf_ev;
            unf_d    = unf_ev;
`endif
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q <= init_lp;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end

        assign count_o[i*cnt_w_lp +: cnt_w_lp] = cnt_q;
        assign zero_o[i]      = (cnt_q == '0);
        assign overflow_o[i]  = ovf_q;
        assign underflow_o[i] = unf_q;

`ifndef SYNTHESIS
        always @(posedge clk_i) begin
            if (!reset_i)
                assert (up <= step_lp && dn <= step_lp)
                else $error("channel %0d step above max_step_p: up=%0d down=%0d", i, up, dn);
        end
`endif
    end
endmodule

// File: tb/tb_bsg_counter_up_down_variable_multi_sat.sv
// tb_bsg_counter_up_down_variable_multi_sat: directed and random checks against an arithmetic reference model
module tb_bsg_counter_up_down_variable_multi_sat;
    localparam int N    = 4;
    localparam int MAX  = 10000000;
    localparam int INIT = 100;
    localparam int CW   = 24;
    localparam int SW   = 3;
    localparam int IW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, load_v, clr;
    logic [IW-1:0]   load_id;
    logic [CW-1:0]   load_val;
    logic [N*SW-1:0] up, dn;
    logic [N*CW-1:0] count;
    logic [N-1:0]    zero, ovf, unf;

    bsg_counter_up_down_variable_multi_sat dut (
        .clk_i(clk), .reset_i(rst), .up_i(up), .down_i(dn),
        .load_v_i(load_v), .load_id_i(load_id), .load_val_i(load_val),
        .clear_err_i(clr), .count_o(count), .zero_o(zero),
        .overflow_o(ovf), .underflow_o(unf)
    );

    int m_cnt[N];
    bit m_ovf[N], m_unf[N];
    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        up = '0; dn = '0; load_v = 0; clr = 0; rst = 0; load_id = '0; load_val = '0;
    endtask

    task automatic set_step(input int c, input int u, input int d);
        up[c*SW +: SW] = SW'(u);
        dn[c*SW +: SW] = SW'(d);
    endtask

    // One clock: the reference model advances on the same edge, then all outputs are compared.
    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            bit ev_o, ev_u;
            int s;
            ev_o = 0; ev_u = 0;
            if (rst) begin
                m_cnt[c] = INIT; m_ovf[c] = 0; m_unf[c] = 0;
            end else begin
                if (load_v && int'(load_id) == c) begin
                    ev_o = int'(load_val) > MAX;
                    m_cnt[c] = ev_o ? MAX : int'(load_val);
                end else begin
                    s = m_cnt[c] - int'(dn[c*SW +: SW]) + int'(up[c*SW +: SW]);
                    ev_u = s < 0;
                    ev_o = s > MAX;
                    m_cnt[c] = ev_u ? 0 : ev_o ? MAX : s;
                end
`ifdef BSG_COUNTER_UP_DOWN_VARIABLE_MULTI_SAT_STICKY_ERR_EN
                m_ovf[c] = ev_o | (m_ovf[c] & !clr);
                m_unf[c] = ev_u | (m_unf[c] & !clr);
`else
                m_ovf[c] = ev_o;
                m_unf[c] = ev_u;
`endif
            end
        end
        #1;
        for (int c = 0; c < N; c++) begin
            check_eq($sformatf("cnt%0d", c), 32'(count[c*CW +: CW]), m_cnt[c]);
            check_eq($sformatf("zero%0d", c), 32'(zero[c]), 32'(m_cnt[c] == 0));
            check_eq($sformatf("ovf%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
            check_eq($sformatf("unf%0d", c), 32'(unf[c]), 32'(m_unf[c]));
        end
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c < N; c++) check_eq("t1_reset", 32'(count[c*CW +: CW]), 100);
        check_eq("t1_zero", 32'(zero), 0);
        check_eq("t1_flags", 32'({ovf, unf}), 0);

        set_step(0, 3, 1);
        repeat (10) tick();
        set_step(0, 0, 0);
        check_eq("t2_ch0", 32'(count[0 +: CW]), 120);
        check_eq("t2_ch1", 32'(count[CW +: CW]), 100);

        set_step(1, 0, 4);
        repeat (25) tick();
        check_eq("t3_ch1_zero_cnt", 32'(count[CW +: CW]), 0);
        check_eq("t3_zero1", 32'(zero[1]), 1);
        check_eq("t3_no_unf_yet", 32'(unf[1]), 0);
        tick();
        set_step(1, 0, 0);
        check_eq("t3_stays0", 32'(count[CW +: CW]), 0);
        check_eq("t3_unf1", 32'(unf[1]), 1);

        load_v = 1; load_id = 2; load_val = 9999998; set_step(2, 4, 0);
        tick();
        load_v = 0;
        check_eq("t4_load", 32'(count[2*CW +: CW]), 9999998);
        check_eq("t4_no_ovf", 32'(ovf[2]), 0);
        tick();
        set_step(2, 0, 0);
        check_eq("t4_sat", 32'(count[2*CW +: CW]), 10000000);
        check_eq("t4_ovf2", 32'(ovf[2]), 1);

        load_v = 1; load_id = 3; load_val = 24'hFFFFFF;
        tick();
        load_v = 0;
        check_eq("t5_clamp", 32'(count[3*CW +: CW]), 10000000);
        check_eq("t5_ovf3", 32'(ovf[3]), 1);
        repeat (5) tick();
`ifdef BSG_COUNTER_UP_DOWN_VARIABLE_MULTI_SAT_STICKY_ERR_EN
        check_eq("t5_sticky_hold", 32'(ovf[3]), 1);
        clr = 1;
        tick();
        clr = 0;
        check_eq("t5_sticky_clr", 32'(ovf[3]), 0);
`else
        check_eq("t5_pulse_low", 32'(ovf[3]), 0);
`endif

        rst = 1; load_v = 1; load_id = 0; load_val = 5;
        tick();
        rst = 0; load_v = 0;
        check_eq("t6_reset_wins", 32'(count[0 +: CW]), 100);
        set_step(0, 2, 2);
        tick();
        set_step(0, 0, 0);
        check_eq("t6_net0", 32'(count[0 +: CW]), 100);

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 9) == 0);
            load_v = ($urandom_range(0, 3) == 0);
            load_id = IW'($urandom_range(0, N - 1));
            case ($urandom_range(0, 2))
                0: load_val = CW'($urandom_range(0, 8));
                1: load_val = CW'(MAX - 8 + $urandom_range(0, 16));
                default: load_val = CW'($urandom);
            endcase
            for (int c = 0; c < N; c++) set_step(c, $urandom_range(0, 4), $urandom_range(0, 4));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
